clusterv_tile_sram_banked: RTL and testbench

Parametrised banked tile SRAM for the clusterv tile. It builds an N-bank memory from sky130_sram_1kbyte_1rw1r_32x256_8 macros (256 x 32 bits, byte-masked) behind the generic byte-enable target port. After reset it zero-fills every bank, because the macros have no reset. It adds ready and read-valid handshakes so the tile core can tell when the memory is usable and when read data is present.

---
 rtl/clusterv_tile_sram_pkg.sv | 24 ++
 rtl/clusterv_tile_sram_banked_if.sv | 29 ++
 rtl/clusterv_tile_sram_init_fsm.sv | 73 +++++++
 rtl/sky130_sram_1kbyte_1rw1r_32x256_8.sv | 50 +++++
 rtl/clusterv_tile_sram_banked.sv | 143 ++++++++++++++
 tb/tb_clusterv_tile_sram_banked.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/clusterv_tile_sram_pkg.sv
// clusterv_tile_sram_pkg
// Shared types and constants for the banked tile SRAM.
// Contents:
//   sram_state_e : INIT (zero-fill running) / RUN (normal traffic)
//   SRAM_ROWS    : rows per sky130 1 KiB macro
//   SRAM_DW      : macro data width
//   SRAM_MASKW   : macro byte-mask width
package clusterv_tile_sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_e;

  localparam int SRAM_ROWS  = 256;
  localparam int SRAM_DW    = 32;
  localparam int SRAM_MASKW = 4;

  // Last row index the zero-fill writes before handing over to RUN.
  function automatic logic [7:0] last_row();
    return 8'(SRAM_ROWS - 1);
  endfunction

endpackage

// File: rtl/clusterv_tile_sram_banked_if.sv
// clusterv_tile_sram_banked_if
// Byte-enable target port of the banked tile SRAM.
// Signals:
//   t_addr/t_read_en/t_write_en/t_byte_en/t_write_data : request (master -> slave)
//   t_read_data/t_read_valid                           : read return (slave -> master)
//   t_ready/init_done                                  : availability (slave -> master)
interface clusterv_tile_sram_banked_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic [ADDR_WIDTH-1:0] t_addr;
  logic                  t_read_en;
  logic                  t_write_en;
  logic [3:0]            t_byte_en;
  logic [31:0]           t_write_data;
  logic [31:0]           t_read_data;
  logic                  t_read_valid;
  logic                  t_ready;
  logic                  init_done;

  modport master (
    output t_addr, t_read_en, t_write_en, t_byte_en, t_write_data,
    input  t_read_data, t_read_valid, t_ready, init_done
  );

  modport slave (
    input  t_addr, t_read_en, t_write_en, t_byte_en, t_write_data,
    output t_read_data, t_read_valid, t_ready, init_done
  );
endinterface

// File: rtl/clusterv_tile_sram_init_fsm.sv
// clusterv_tile_sram_init_fsm
// Owns the INIT/RUN state, the zero-fill row counter and the availability
// flags of the banked SRAM.
// Ports:
//   clock, reset (async active-low)
//   init_active : high while the zero-fill drives every bank
//   init_row    : row being zero-filled this cycle
//   ready       : registered, high in RUN
//   init_done   : registered, sticky high once RUN is reached
module clusterv_tile_sram_init_fsm
  import clusterv_tile_sram_pkg::*;
#(
  parameter int INIT_ZERO = 1
) (
  input  logic       clock,
  input  logic       reset,
  output logic       init_active,
  output logic [7:0] init_row,
  output logic       ready,
  output logic       init_done
);
  localparam sram_state_e RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

  sram_state_e state_r, state_s;
  logic [7:0]  row_r, row_s;
  logic        ready_r, done_r;

  // Next state: walk rows 0..255 in INIT, then hold RUN.
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    case (state_r)
      ST_INIT: begin
        if (row_r == last_row()) begin
          state_s = ST_RUN;
          row_s   = 8'd0;
        end else begin
          state_s = ST_INIT;
          row_s   = row_r + 8'd1;
        end
      end
      ST_RUN: begin
        state_s = ST_RUN;
        row_s   = 8'd0;
      end
      default: begin
        state_s = RESET_STATE;
        row_s   = 8'd0;
      end
    endcase
  end

  // State, counter and registered flags; flags follow the next state so
  // ready rises on the same edge that writes the last row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= RESET_STATE;
      row_r   <= 8'd0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      row_r   <= row_s;
      ready_r <= (state_s == ST_RUN);
      done_r  <= done_r | (state_s == ST_RUN);
    end
  end

  assign init_active = (state_r == ST_INIT);
  assign init_row    = row_r;
  assign ready       = ready_r;
  assign init_done   = done_r;
endmodule

// File: rtl/sky130_sram_1kbyte_1rw1r_32x256_8.sv
// sky130_sram_1kbyte_1rw1r_32x256_8
// Cycle-level behavioural stand-in for the OpenRAM 256 x 32 macro.
// Port 0 (rw): clk0, csb0 (active-low select), web0 (active-low write),
//              wmask0 (byte mask), addr0, din0, dout0 (registered read data).
// Port 1 (r) : clk1, csb1, addr1, dout1.
// Writes land in the array at the clock edge, so a read on the next edge
// sees the new contents. The array has no reset, like the real macro.
module sky130_sram_1kbyte_1rw1r_32x256_8
  import clusterv_tile_sram_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire                  vccd1,
  inout  wire                  vssd1,
`endif
  input  logic                  clk0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [SRAM_MASKW-1:0] wmask0,
  input  logic [7:0]            addr0,
  input  logic [SRAM_DW-1:0]    din0,
  output logic [SRAM_DW-1:0]    dout0,
  input  logic                  clk1,
  input  logic                  csb1,
  input  logic [7:0]            addr1,
  output logic [SRAM_DW-1:0]    dout1
);
  logic [SRAM_DW-1:0] mem_r [SRAM_ROWS];

  // Port 0: masked byte write or registered read.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < SRAM_MASKW; i++) begin
          if (wmask0[i]) begin
            mem_r[addr0][i*8 +: 8] <= din0[i*8 +: 8];
          end
        end
      end else begin
        dout0 <= mem_r[addr0];
      end
    end
  end

  // Port 1: read-only port.
  always_ff @(posedge clk1) begin
    if (!csb1) begin
      dout1 <= mem_r[addr1];
    end
  end
endmodule

// File: rtl/clusterv_tile_sram_banked.sv
// clusterv_tile_sram_banked
// N-bank tile SRAM built from sky130 1 KiB macros behind the byte-enable
// target port, with zero-fill after reset and ready/read-valid handshakes.
// Ports:
//   vccd1/vssd1 : macro power (only with USE_POWER_PINS)
//   clock       : block and macro clock
//   reset       : async active-low
//   bus         : target port (slave modport); t_addr low BANK_AW bits pick
//                 the row, upper bits pick the bank. Read latency is 1.
module clusterv_tile_sram_banked
  import clusterv_tile_sram_pkg::*;
#(
  parameter int N_BANKS    = 4,
  parameter int BANK_AW    = 8,
  parameter int ADDR_WIDTH = BANK_AW + $clog2(N_BANKS),
  parameter int INIT_ZERO  = 1
) (
`ifdef USE_POWER_PINS
  inout  wire  vccd1,
  inout  wire  vssd1,
`endif
  input  logic clock,
  input  logic reset,
  clusterv_tile_sram_banked_if.slave bus
);
  // A single bank still needs a one-bit index for the return mux.
  localparam int BANK_BITS = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  logic                 init_active_s;
  logic [7:0]           init_row_s;
  logic                 ready_s;
  logic                 init_done_s;
  logic [BANK_BITS-1:0] bank_sel_s;
  logic                 write_s;
  logic                 read_s;
  logic                 accept_s;
  logic [SRAM_DW-1:0]   bank_dout_s [N_BANKS];
  logic [BANK_BITS-1:0] bank_q;
  logic                 pending_r;
  logic [SRAM_DW-1:0]   read_data_s;

  clusterv_tile_sram_init_fsm #(
    .INIT_ZERO (INIT_ZERO)
  ) u_init_fsm (
    .clock       (clock),
    .reset       (reset),
    .init_active (init_active_s),
    .init_row    (init_row_s),
    .ready       (ready_s),
    .init_done   (init_done_s)
  );

  if (N_BANKS > 1) begin : g_sel
    assign bank_sel_s = bus.t_addr[ADDR_WIDTH-1:BANK_AW];
  end else begin : g_sel_one
    assign bank_sel_s = 1'b0;
  end

  // Write wins over a simultaneous read: such a request performs no read.
  assign accept_s = ready_s & (bus.t_read_en | bus.t_write_en);
  assign write_s  = ready_s & bus.t_write_en;
  assign read_s   = ready_s & bus.t_read_en & ~bus.t_write_en;

  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
    logic                  csb_s;
    logic                  web_s;
    logic [SRAM_MASKW-1:0] wmask_s;
    logic [BANK_AW-1:0]    addr_s;
    logic [SRAM_DW-1:0]    din_s;

    // Bank port 0 source: the zero-fill in INIT, the decoded request otherwise.
    always_comb begin
      csb_s   = 1'b1;
      web_s   = 1'b1;
      wmask_s = 4'h0;
      addr_s  = {BANK_AW{1'b0}};
      din_s   = 32'h0;
      if (init_active_s) begin
        csb_s   = 1'b0;
        web_s   = 1'b0;
        wmask_s = 4'hF;
        addr_s  = init_row_s;
        din_s   = 32'h0;
      end else begin
        csb_s   = ~(accept_s & (bank_sel_s == BANK_BITS'(gi)));
        web_s   = ~write_s;
        wmask_s = bus.t_byte_en;
        addr_s  = bus.t_addr[BANK_AW-1:0];
        din_s   = bus.t_write_data;
      end
    end

    sky130_sram_1kbyte_1rw1r_32x256_8 u_macro (
`ifdef USE_POWER_PINS
      .vccd1  (vccd1),
      .vssd1  (vssd1),
`endif
      .clk0   (clock),
      .csb0   (csb_s),
      .web0   (web_s),
      .wmask0 (wmask_s),
      .addr0  (addr_s),
      .din0   (din_s),
      .dout0  (bank_dout_s[gi]),
      .clk1   (1'b0),
      .csb1   (1'b1),
      .addr1  (8'h00),
      .dout1  ()
    );
  end

  // Read return tracking: remember which bank answers and flag the valid cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_r <= 1'b0;
      bank_q    <= {BANK_BITS{1'b0}};
    end else begin
      pending_r <= read_s;
      if (read_s) begin
        bank_q <= bank_sel_s;
      end else begin
        bank_q <= bank_q;
      end
    end
  end

  // Return mux; gated by the valid flag so reset shows zero on the data bus.
  always_comb begin
    read_data_s = 32'h0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (pending_r && (bank_q == BANK_BITS'(b))) begin
        read_data_s = bank_dout_s[b];
      end else begin
        read_data_s = read_data_s;
      end
    end
  end

  assign bus.t_read_data  = read_data_s;
  assign bus.t_read_valid = pending_r;
  assign bus.t_ready      = ready_s;
  assign bus.init_done    = init_done_s;
endmodule

// File: tb/tb_clusterv_tile_sram_banked.sv
// tb_clusterv_tile_sram_banked
// Self-checking bench: a 4-bank zero-fill instance driven by a vector table,
// hand-written reset sequences and random traffic against a word-array model,
// plus a 1-bank instance without zero-fill.
module tb_clusterv_tile_sram_banked;
  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;

  always #5 clock = ~clock;

  clusterv_tile_sram_banked_if #(.ADDR_WIDTH(10)) if_a ();
  clusterv_tile_sram_banked_if #(.ADDR_WIDTH(8))  if_b ();

  clusterv_tile_sram_banked #(
    .N_BANKS(4), .INIT_ZERO(1)
  ) dut_a (
    .clock (clock),
    .reset (reset_a),
    .bus   (if_a)
  );

  clusterv_tile_sram_banked #(
    .N_BANKS(1), .INIT_ZERO(0)
  ) dut_b (
    .clock (clock),
    .reset (reset_b),
    .bus   (if_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_mem [1024];

  typedef struct {
    logic        we;
    logic        re;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
  endtask

  // Byte-merge a write into the reference array.
  task automatic model_write(input logic [9:0] addr, input logic [3:0] be, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) model_mem[addr][i*8 +: 8] = d[i*8 +: 8];
    end
  endtask

  task automatic drive_a(input logic we, input logic re, input logic [9:0] addr,
                         input logic [3:0] be, input logic [31:0] d);
    if_a.t_write_en   = we;
    if_a.t_read_en    = re;
    if_a.t_addr       = addr;
    if_a.t_byte_en    = be;
    if_a.t_write_data = d;
  endtask

  // One request cycle on dut_a; the reference array follows accepted writes.
  task automatic op_a(input logic we, input logic re, input logic [9:0] addr,
                      input logic [3:0] be, input logic [31:0] d);
    drive_a(we, re, addr, be, d);
    tick();
    if (we) model_write(addr, be, d);
  endtask

  task automatic wait_ready_a(output int n);
    n = 0;
    while (if_a.t_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic add_vec(input logic we, input logic re, input logic [9:0] addr, input logic [3:0] be,
                         input logic [31:0] d, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.be = be; v.wdata = d;
    v.exp_valid = ev; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    logic [31:0] exp_d;
    logic        we, re;
    logic [9:0]  addr;
    logic [3:0]  a4;

    reset_a = 1'b0;
    reset_b = 1'b0;
    drive_a(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    if_b.t_write_en = 1'b0; if_b.t_read_en = 1'b0; if_b.t_addr = 8'h0;
    if_b.t_byte_en = 4'h0; if_b.t_write_data = 32'h0;
    model_clear();

    // Reset values.
    tick(); tick();
    check("rst_ready", {31'h0, if_a.t_ready}, 32'h0);
    check("rst_valid", {31'h0, if_a.t_read_valid}, 32'h0);
    check("rst_done", {31'h0, if_a.init_done}, 32'h0);
    check("rst_data", if_a.t_read_data, 32'h0);

    // Zero-fill length.
    reset_a = 1'b1;
    wait_ready_a(n);
    check("init_cycles", n, 256);
    check("init_done", {31'h0, if_a.init_done}, 32'h1);

    // Directed table.
    add_vec(1'b0, 1'b1, 10'h000, 4'h0, 32'h0, 1'b1, 32'h0);
    add_vec(1'b0, 1'b1, 10'h0FF, 4'h0, 32'h0, 1'b1, 32'h0);
    add_vec(1'b0, 1'b1, 10'h100, 4'h0, 32'h0, 1'b1, 32'h0);
    add_vec(1'b0, 1'b1, 10'h3FF, 4'h0, 32'h0, 1'b1, 32'h0);
    add_vec(1'b0, 1'b0, 10'h000, 4'h0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b1, 1'b0, 10'h105, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
    add_vec(1'b1, 1'b0, 10'h105, 4'b0101, 32'h11223344, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 10'h105, 4'h0, 32'h0, 1'b1, 32'hDE22BE44);
    add_vec(1'b1, 1'b0, 10'h000, 4'hF, 32'h0, 1'b0, 32'h0);
    add_vec(1'b1, 1'b0, 10'h100, 4'hF, 32'h1, 1'b0, 32'h0);
    add_vec(1'b1, 1'b0, 10'h200, 4'hF, 32'h2, 1'b0, 32'h0);
    add_vec(1'b1, 1'b0, 10'h300, 4'hF, 32'h3, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 10'h000, 4'h0, 32'h0, 1'b1, 32'h0);
    add_vec(1'b0, 1'b1, 10'h100, 4'h0, 32'h0, 1'b1, 32'h1);
    add_vec(1'b0, 1'b1, 10'h200, 4'h0, 32'h0, 1'b1, 32'h2);
    add_vec(1'b0, 1'b1, 10'h300, 4'h0, 32'h0, 1'b1, 32'h3);
    add_vec(1'b0, 1'b0, 10'h300, 4'h0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b1, 1'b1, 10'h010, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 10'h010, 4'h0, 32'h0, 1'b1, 32'h5A5A5A5A);
    add_vec(1'b1, 1'b0, 10'h020, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 10'h020, 4'h0, 32'h0, 1'b1, 32'h0);

    foreach (vecs[i]) begin
      op_a(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      check($sformatf("vec%0d_valid", i), {31'h0, if_a.t_read_valid}, {31'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), if_a.t_read_data, vecs[i].exp_data);
      end
    end

    // Random traffic over 16 addresses spread across all banks.
    for (int i = 0; i < 400; i++) begin
      a4    = 4'($urandom_range(0, 15));
      addr  = {a4[3:2], 6'd0, a4[1:0]};
      n     = int'($urandom_range(0, 3));
      re    = n[0];
      we    = n[1];
      exp_d = model_mem[addr];
      op_a(we, re, addr, 4'($urandom_range(0, 15)), $urandom);
      check($sformatf("rnd%0d_valid", i), {31'h0, if_a.t_read_valid}, {31'h0, re & ~we});
      if (re && !we) check($sformatf("rnd%0d_data", i), if_a.t_read_data, exp_d);
    end
    drive_a(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    tick();

    // Reset in the middle of the zero-fill at row 100.
    reset_a = 1'b0;
    tick();
    reset_a = 1'b1;
    repeat (100) tick();
    check("midfill_ready", {31'h0, if_a.t_ready}, 32'h0);
    reset_a = 1'b0;
    #1;
    check("midfill_rst_done", {31'h0, if_a.init_done}, 32'h0);
    tick(); tick();
    reset_a = 1'b1;
    wait_ready_a(n);
    check("refill_cycles", n, 256);
    model_clear();

    // Reset right after a read is accepted drops the pending return.
    op_a(1'b0, 1'b1, 10'h105, 4'h0, 32'h0);
    check("pre_rst_valid", {31'h0, if_a.t_read_valid}, 32'h1);
    drive_a(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    reset_a = 1'b0;
    #1;
    check("run_rst_valid", {31'h0, if_a.t_read_valid}, 32'h0);
    check("run_rst_ready", {31'h0, if_a.t_ready}, 32'h0);
    tick();
    check("run_rst_valid_hold", {31'h0, if_a.t_read_valid}, 32'h0);
    reset_a = 1'b1;
    wait_ready_a(n);
    check("rerun_cycles", n, 256);
    op_a(1'b0, 1'b1, 10'h105, 4'h0, 32'h0);
    check("cleared_data", if_a.t_read_data, 32'h0);
    drive_a(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);

    // Single bank, no zero-fill.
    reset_b = 1'b1;
    #1;
    check("b_pre_ready", {31'h0, if_b.t_ready}, 32'h0);
    tick();
    check("b_ready", {31'h0, if_b.t_ready}, 32'h1);
    check("b_done", {31'h0, if_b.init_done}, 32'h1);
    if_b.t_write_en = 1'b1; if_b.t_addr = 8'hFF; if_b.t_byte_en = 4'hF;
    if_b.t_write_data = 32'hC0FFEE42;
    tick();
    check("b_wr_valid", {31'h0, if_b.t_read_valid}, 32'h0);
    if_b.t_write_en = 1'b0; if_b.t_read_en = 1'b1;
    tick();
    check("b_rd_valid", {31'h0, if_b.t_read_valid}, 32'h1);
    check("b_rd_data", if_b.t_read_data, 32'hC0FFEE42);
    if_b.t_read_en = 1'b0;
    tick();
    check("b_valid_drop", {31'h0, if_b.t_read_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
